adder_accumulator_ctrl: RTL and testbench
=========================================

# adder_accumulator_ctrl

Sequential control and register stage that feeds the 16-bit combinational adder and captures its result. It holds the accumulator operand A and the switch operand B, drives both into the adder, and waits a fixed settle time on each Run press. It then writes Sum/CO back into A and a carry flag. The block sits between the board inputs (switches, buttons) and the adder; the adder itself stays outside it.

## Interface
- WIDTH, 16: operand/result width; must match the adder width.
- SETTLE_CYCLES, 2: cycles the adder inputs are held stable before capture; legal range ≥1.

- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Run  in  1  level, active-high, already synchronized; each rising edge requests one add.
- ClearA_LoadB  in  1  level, active-high; clears A and loads B from SW.
- SW  in  WIDTH  switch operand.
- Sum  in  WIDTH  adder sum output.
- CO  in  1  adder carry output.
- A  out  WIDTH  accumulator, to adder A.
- B  out  WIDTH  operand register, to adder B.
- Carry  out  1  carry-out of the last completed add.
- Busy  out  1  high whenever the state is not IDLE.
- Done  out  1  one-cycle pulse when A is updated.

## Operation
- Reset values: A=0, B=0, Carry=0, Done=0, Busy=0, state=IDLE, run_q=1.
	- run_q resets to 1 so that Run held high through reset release does not trigger an add.
- Edge detect: run_rise = Run & ~run_q; run_q <= Run every cycle.
- States: IDLE, ADD, HOLD.
- IDLE:
	- ClearA_LoadB=1: A<=0, B<=SW, Carry<=0; remain in IDLE.
	- Else, if run_rise: go to ADD and load cnt<=SETTLE_CYCLES-1.
	- If ClearA_LoadB and run_rise occur together, clear/load wins and the Run edge is discarded.
- ADD:
	- A and B stay frozen.
	- If cnt≠0: cnt<=cnt-1.
	- If cnt=0: A<=Sum, Carry<=CO, Done<=1, go to HOLD.
- HOLD:
	- Done<=0.
	- Leave for IDLE on the first cycle Run is sampled low.
	- Run rising again requires release first, so each press gives exactly one add.
- ClearA_LoadB is ignored in ADD and HOLD. SW is ignored except during a load.
- Arithmetic: A wraps modulo 2^WIDTH. Carry is not sticky; it reflects only the last add and is cleared by a load.
- Reset asserted mid-operation: all registers return to reset values immediately. The partial add is discarded and Done is not pulsed.

## Timing
- Load: A/B update on the edge that samples ClearA_LoadB=1 (latency 1).
- Add: if run_rise is sampled at edge k, state=ADD from k. A, Carry and Done update at edge k+SETTLE_CYCLES.
- Done is high for exactly one cycle, coincident with the first cycle the new A is visible.
- Busy rises at edge k. It falls on the edge after Run is sampled low in HOLD, minimum at edge k+SETTLE_CYCLES+1.
- Back-to-back presses need at least one low sample of Run between them.
- Adder path budget: ripple delay must fit in SETTLE_CYCLES clock periods. Multicycle constraint A/B→Sum/CO = SETTLE_CYCLES.

## Structure
- Shared package adder_pkg holds:
	- typedef enum logic [1:0] {IDLE, ADD, HOLD} acc_state_t;
	- localparam ADDER_WIDTH = 16.
- One natural sub-module: run_edge_detect (run_q register plus rise output, reset-to-1).
- Counter width: $clog2(SETTLE_CYCLES+1).
- The top level instantiates adder_accumulator_ctrl alongside the adder, wiring A/B out and Sum/CO back.

## Test plan
- Reset low for 3 cycles with Run=1 held, then release -> A=0x0000, B=0x0000, Carry=0, Busy=0, and no Done for 10 cycles.
- Apply ClearA_LoadB with SW=0x0005, then press Run twice -> A=0x0005 at edge k+2 with a single Done pulse; after the second press A=0x000A, Carry=0.
- Load B=0x8000, then press Run twice -> A=0x8000, Carry=0, then A=0x0000, Carry=1.
- Hold Run high for 20 cycles -> exactly one Done and one increment of A; Busy stays high until Run falls, then goes low one cycle later.
- In IDLE, raise ClearA_LoadB and Run on the same edge with SW=0x0003 -> A=0, B=0x0003, no add. Then, during ADD, pulse ClearA_LoadB with SW=0xFFFF -> B stays 0x0003.
- Assert Reset during the first ADD cycle with A=0x1234 -> A=0, Carry=0, Done never asserts, state=IDLE.

Source files
------------

// File: rtl/adder_pkg.sv
// adder_pkg: shared state encoding and width for the adder accumulator slice
package adder_pkg;

    typedef enum logic [1:0] {IDLE, ADD, HOLD} acc_state_t;

    localparam int ADDER_WIDTH = 16;

endpackage

// File: rtl/run_edge_detect.sv
// run_edge_detect: rising-edge detector whose history resets high so a held input stays quiet
module run_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= 1'b1;
        else        q <= d;

    assign rise = d & ~q;

endmodule

// File: rtl/adder_accumulator_ctrl.sv
// adder_accumulator_ctrl: holds A/B for an external adder and captures Sum/CO once per Run press
module adder_accumulator_ctrl
    import adder_pkg::*;
#(
    parameter int WIDTH         = ADDER_WIDTH,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             ClearA_LoadB,
    input  logic [WIDTH-1:0] SW,
    input  logic [WIDTH-1:0] Sum,
    input  logic             CO,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             Carry,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    acc_state_t    state;
    logic [CW-1:0] cnt;
    logic          run_rise;

    run_edge_detect u_run_edge (
        .clk  (Clk),
        .rst_n(Reset),
        .d    (Run),
        .rise (run_rise)
    );

    // A/B stay frozen outside IDLE so the adder sees stable inputs for the whole settle window
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            cnt   <= '0;
            A     <= '0;
            B     <= '0;
            Carry <= 1'b0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ClearA_LoadB) begin
                        A     <= '0;
                        B     <= SW;
                        Carry <= 1'b0;
                    end else if (run_rise) begin
                        state <= ADD;
                        cnt   <= CW'(SETTLE_CYCLES - 1);
                        Busy  <= 1'b1;
                    end
                end
                ADD: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        A     <= Sum;
                        Carry <= CO;
                        Done  <= 1'b1;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (!Run) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_accumulator_ctrl.sv
// tb_adder_accumulator_ctrl: directed plus randomized checks against a transaction-level model
module tb_adder_accumulator_ctrl;

    localparam int W = 16;
    localparam int S = 2;

    logic         Clk = 1'b0;
    logic         Reset = 1'b0;
    logic         Run = 1'b1;
    logic         ClearA_LoadB = 1'b0;
    logic [W-1:0] SW = '0;
    logic [W-1:0] Sum;
    logic         CO;
    logic [W-1:0] A, B;
    logic         Carry, Busy, Done;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_a = '0, exp_b = '0;
    logic         exp_c = 1'b0;

    always #5 Clk = ~Clk;

    // stand-in for the external combinational adder
    assign {CO, Sum} = {1'b0, A} + {1'b0, B};

    adder_accumulator_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB),
        .SW(SW), .Sum(Sum), .CO(CO), .A(A), .B(B),
        .Carry(Carry), .Busy(Busy), .Done(Done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic load(input logic [W-1:0] sw);
        ClearA_LoadB = 1'b1;
        SW = sw;
        @(negedge Clk);
        ClearA_LoadB = 1'b0;
        SW = W'($urandom);
        exp_a = '0;
        exp_b = sw;
        exp_c = 1'b0;
        check("load_a", A, exp_a);
        check("load_b", B, exp_b);
        check("load_carry", Carry, exp_c);
        check("load_busy", Busy, 0);
    endtask

    // one press: Run high for S+1+hold sampled cycles, then released
    task automatic press(input int hold, input bit noise);
        logic [W-1:0] a0;
        int           s;
        int           dn;
        a0 = exp_a;
        s = int'(exp_a) + int'(exp_b);
        exp_a = W'(s);
        exp_c = s[W];
        dn = 0;
        Run = 1'b1;
        for (int i = 1; i <= S + 1; i++) begin
            @(negedge Clk);
            dn += int'(Done);
            check("press_busy", Busy, 1);
            if (i <= S) begin
                check("settle_a_frozen", A, a0);
                if (noise) begin
                    ClearA_LoadB = 1'b1;
                    SW = W'($urandom);
                end
            end else begin
                check("add_a", A, exp_a);
                check("add_carry", Carry, exp_c);
                check("add_done", Done, 1);
            end
        end
        ClearA_LoadB = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge Clk);
            dn += int'(Done);
            check("hold_busy", Busy, 1);
            check("hold_a", A, exp_a);
        end
        Run = 1'b0;
        @(negedge Clk);
        dn += int'(Done);
        check("release_busy", Busy, 0);
        check("release_a", A, exp_a);
        check("keep_b", B, exp_b);
        check("done_pulses", dn, 1);
    endtask

    initial begin
        int dn;
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        check("rst_a", A, 0);
        check("rst_b", B, 0);
        check("rst_carry", Carry, 0);
        check("rst_busy", Busy, 0);
        dn = 0;
        repeat (10) begin
            @(negedge Clk);
            dn += int'(Done);
        end
        check("rst_no_done", dn, 0);
        check("rst_idle_busy", Busy, 0);
        Run = 1'b0;
        @(negedge Clk);

        load(16'h0005);
        press(0, 1'b0);
        press(1, 1'b0);
        check("five_plus_five", A, 16'h000A);

        load(16'h8000);
        press(0, 1'b0);
        press(0, 1'b0);
        check("wrap_a", A, 16'h0000);
        check("wrap_carry", Carry, 1);

        press(19, 1'b0);

        ClearA_LoadB = 1'b1;
        Run = 1'b1;
        SW = 16'h0003;
        @(negedge Clk);
        exp_a = '0;
        exp_b = 16'h0003;
        exp_c = 1'b0;
        check("tie_a", A, 0);
        check("tie_b", B, 16'h0003);
        check("tie_busy", Busy, 0);
        ClearA_LoadB = 1'b0;
        repeat (3) @(negedge Clk);
        check("tie_no_add_busy", Busy, 0);
        check("tie_no_add_a", A, 0);
        Run = 1'b0;
        @(negedge Clk);
        press(0, 1'b1);
        check("noise_b", B, 16'h0003);

        load(16'h1234);
        press(0, 1'b0);
        check("pre_reset_a", A, 16'h1234);
        Run = 1'b1;
        @(negedge Clk);
        check("abort_in_add", Busy, 1);
        Reset = 1'b0;
        #1;
        exp_a = '0;
        exp_b = '0;
        exp_c = 1'b0;
        check("abort_a", A, 0);
        check("abort_b", B, 0);
        check("abort_carry", Carry, 0);
        check("abort_busy", Busy, 0);
        check("abort_done", Done, 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        dn = 0;
        repeat (6) begin
            @(negedge Clk);
            dn += int'(Done);
        end
        check("abort_no_done", dn, 0);
        check("abort_idle", Busy, 0);
        check("abort_a_after", A, 0);
        Run = 1'b0;
        @(negedge Clk);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) load(W'($urandom));
            else press(int'($urandom_range(0, 4)), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge Clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
